// File: rtl/serial_paralelo_param.sv
// Serial-to-parallel receiver that aligns on a comma symbol at any bit phase and emits
// one strobe per non-comma word once SYNC_COUNT aligned commas have been seen in a row.
module serial_paralelo_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               SYNC_COUNT = 4,
  parameter bit               MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             data_in,
  input  logic             resync,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             lock_out
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CCW = $clog2(SYNC_COUNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] nsr;
  logic [BCW-1:0]   bit_cnt;
  logic [CCW-1:0]   comma_cnt;
  logic             boundary;
  logic             is_comma;
  logic             last_sync;

  // Every decision looks at the register value including the bit being sampled now.
  always_comb begin
    if (MSB_FIRST) nsr = {sr[WIDTH-2:0], data_in};
    else           nsr = {data_in, sr[WIDTH-1:1]};
  end

  assign boundary  = (bit_cnt == BCW'(WIDTH - 1));
  assign is_comma  = (nsr == COMMA);
  assign last_sync = ((int'(comma_cnt) + 1) == SYNC_COUNT);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sr        <= '0;
      state     <= HUNT;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      lock_out  <= 1'b0;
    end else begin
      sr        <= nsr;
      valid_out <= 1'b0;
      bit_cnt   <= boundary ? '0 : bit_cnt + 1'b1;

      if (resync) begin
        // Resync wins over anything completing on this edge, including a comma.
        state     <= HUNT;
        comma_cnt <= '0;
        lock_out  <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (is_comma) begin
              bit_cnt   <= '0;
              comma_cnt <= CCW'(1);
              if (SYNC_COUNT == 1) begin
                state    <= ACTIVE;
                lock_out <= 1'b1;
              end else begin
                state <= ALIGN;
              end
            end
          end
          ALIGN: begin
            if (boundary) begin
              if (is_comma) begin
                comma_cnt <= comma_cnt + 1'b1;
                if (last_sync) begin
                  state    <= ACTIVE;
                  lock_out <= 1'b1;
                end
              end else begin
                state     <= HUNT;
                comma_cnt <= '0;
              end
            end
          end
          ACTIVE: begin
            if (boundary && !is_comma) begin
              data_out  <= nsr;
              valid_out <= 1'b1;
            end
          end
          default: begin
            state     <= HUNT;
            comma_cnt <= '0;
            lock_out  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_paralelo_param.sv
// Directed bench for serial_paralelo_param: default 8-bit MSB-first instance plus a
// 10-bit LSB-first instance with SYNC_COUNT=2.
module tb_serial_paralelo_param;

  logic       clk;
  logic       reset_L;
  logic       din;
  logic       resync;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lock_out;

  logic       din6;
  logic       resync6;
  logic [9:0] data_out6;
  logic       valid_out6;
  logic       lock_out6;

  int checks = 0;
  int errors = 0;

  serial_paralelo_param dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in   (din),
    .resync    (resync),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lock_out  (lock_out)
  );

  serial_paralelo_param #(
    .WIDTH      (10),
    .COMMA      (10'h0FA),
    .SYNC_COUNT (2),
    .MSB_FIRST  (1'b0)
  ) dut6 (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in   (din6),
    .resync    (resync6),
    .data_out  (data_out6),
    .valid_out (valid_out6),
    .lock_out  (lock_out6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    logic       exp_lock;
    logic       exp_vld;
    logic [7:0] exp_data;
  } vec_t;

  vec_t seq_a[8];
  vec_t seq_b[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send8(input vec_t v, input string tag);
    for (int i = 7; i >= 0; i--) begin
      din = v.word[i];
      step();
      if (i != 0) chk({tag, " mid valid"}, 16'(valid_out), 16'h0);
    end
    chk({tag, " lock"},  16'(lock_out),  16'(v.exp_lock));
    chk({tag, " valid"}, 16'(valid_out), 16'(v.exp_vld));
    chk({tag, " data"},  16'(data_out),  16'(v.exp_data));
  endtask

  task automatic send10(input logic [9:0] w, input logic el, input logic ev,
                        input logic [9:0] ed, input string tag);
    for (int i = 0; i < 10; i++) begin
      din6 = w[i];
      step();
      if (i != 9) chk({tag, " mid valid"}, 16'(valid_out6), 16'h0);
    end
    chk({tag, " lock"},  16'(lock_out6),  16'(el));
    chk({tag, " valid"}, 16'(valid_out6), 16'(ev));
    chk({tag, " data"},  16'(data_out6),  16'(ed));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ffw;

    // lock after 4 commas, one data word, then commas while locked and a second word
    seq_a[0] = '{8'hBC, 1'b0, 1'b0, 8'h00};
    seq_a[1] = '{8'hBC, 1'b0, 1'b0, 8'h00};
    seq_a[2] = '{8'hBC, 1'b0, 1'b0, 8'h00};
    seq_a[3] = '{8'hBC, 1'b1, 1'b0, 8'h00};
    seq_a[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A};
    seq_a[5] = '{8'hBC, 1'b1, 1'b0, 8'h5A};
    seq_a[6] = '{8'hBC, 1'b1, 1'b0, 8'h5A};
    seq_a[7] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
    // broken alignment after resync, then relock
    seq_b[0] = '{8'hBC, 1'b0, 1'b0, 8'hA5};
    seq_b[1] = '{8'hBC, 1'b0, 1'b0, 8'hA5};
    seq_b[2] = '{8'h00, 1'b0, 1'b0, 8'hA5};
    seq_b[3] = '{8'hBC, 1'b0, 1'b0, 8'hA5};
    seq_b[4] = '{8'hBC, 1'b0, 1'b0, 8'hA5};
    seq_b[5] = '{8'hBC, 1'b0, 1'b0, 8'hA5};
    seq_b[6] = '{8'hBC, 1'b1, 1'b0, 8'hA5};
    seq_b[7] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
    seq_b[8] = '{8'h00, 1'b1, 1'b1, 8'h00};

    reset_L = 1'b0;
    din     = 1'b0;
    resync  = 1'b0;
    din6    = 1'b0;
    resync6 = 1'b0;

    // reset held while data toggles
    for (int i = 0; i < 5; i++) begin
      din  = ~din;
      din6 = ~din6;
      step();
    end
    chk("reset data",   16'(data_out),  16'h0);
    chk("reset valid",  16'(valid_out), 16'h0);
    chk("reset lock",   16'(lock_out),  16'h0);
    chk("reset6 data",  16'(data_out6), 16'h0);
    chk("reset6 lock",  16'(lock_out6), 16'h0);
    din  = 1'b0;
    din6 = 1'b0;
    #2 reset_L = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("post-reset data",  16'(data_out),  16'h0);
    chk("post-reset valid", 16'(valid_out), 16'h0);
    chk("post-reset lock",  16'(lock_out),  16'h0);

    // 10-bit LSB-first instance, SYNC_COUNT=2
    send10(10'h0FA, 1'b0, 1'b0, 10'h000, "w10 comma1");
    send10(10'h0FA, 1'b1, 1'b0, 10'h000, "w10 comma2");
    send10(10'h155, 1'b1, 1'b1, 10'h155, "w10 data");

    // main instance: 3-bit preamble of zeros then table
    din = 1'b0;
    for (int i = 0; i < 3; i++) step();
    for (int k = 0; k < 8; k++) send8(seq_a[k], $sformatf("seqA[%0d]", k));

    // resync on the 4th bit of a data word
    ffw = 8'hFF;
    for (int i = 7; i >= 4; i--) begin
      din = ffw[i];
      resync = (i == 4);
      step();
      chk("resync word valid", 16'(valid_out), 16'h0);
    end
    resync = 1'b0;
    chk("resync lock drop", 16'(lock_out), 16'h0);
    for (int i = 3; i >= 0; i--) begin
      din = ffw[i];
      step();
      chk("resync tail valid", 16'(valid_out), 16'h0);
    end
    chk("resync data hold", 16'(data_out), 16'h00A5);
    chk("resync lock stay", 16'(lock_out), 16'h0);

    for (int k = 0; k < 8; k++) send8(seq_b[k], $sformatf("seqB[%0d]", k));

    // asynchronous reset in the middle of a word while locked
    din = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre-reset lock", 16'(lock_out), 16'h1);
    chk("pre-reset data", 16'(data_out), 16'h003C);
    #2 reset_L = 1'b0;
    #1;
    chk("async reset data",  16'(data_out),  16'h0);
    chk("async reset valid", 16'(valid_out), 16'h0);
    chk("async reset lock",  16'(lock_out),  16'h0);
    chk("async reset lock6", 16'(lock_out6), 16'h0);
    chk("async reset data6", 16'(data_out6), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_param.md
Name: serial_paralelo_param

Overview:
Parametrised single-clock serial-to-parallel converter for the PHY receive path. Performs bit-level comma alignment with no fixed word phase, and declares lock after SYNC_COUNT consecutive aligned commas. Once locked, emits each non-comma word as a one-cycle strobe. Sits after the serial line, ahead of the receive-side byte un-striping logic, and supports configurable word width, comma value, bit order and resync.

Parameters:
WIDTH, 8, deserialised word width in bits (>=2)
COMMA, 8'hBC, WIDTH-bit alignment/idle symbol
SYNC_COUNT, 4, consecutive aligned commas required for lock (>=1)
MSB_FIRST, 1, 1 = first serial bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0]

Ports:
clk  input  1  serial bit clock, one bit per rising edge
reset_L  input  1  asynchronous active-low reset
data_in  input  1  serial data, sampled every rising edge of clk
resync  input  1  synchronous request to drop lock and re-hunt
data_out  output  WIDTH  last received non-comma word (registered)
valid_out  output  1  one-cycle strobe when data_out is updated
lock_out  output  1  high while in ACTIVE

Behaviour:
- Clock/reset: one clock (clk); reset_L is asynchronous, active-low.
- Reset values: shift reg=0, state=HUNT, bit_cnt=0, comma_cnt=0, data_out=0, valid_out=0, lock_out=0. Reset asserted mid-word clears all state immediately; no partial word survives.
- Shift every edge:
  - MSB_FIRST=1: nsr={sr[WIDTH-2:0],data_in}.
  - MSB_FIRST=0: nsr={data_in,sr[WIDTH-1:1]}.
  - All comparisons use nsr, so a word is decided on the edge that samples its last bit.
- Word boundary: bit_cnt==WIDTH-1. bit_cnt counts 0..WIDTH-1 and wraps; it is reset to 0 when alignment is found.
- State HUNT:
  - Checks nsr every bit. On nsr==COMMA: bit_cnt<=0, comma_cnt<=1.
  - Next state is ALIGN, or ACTIVE if SYNC_COUNT==1.
  - valid_out=0 in HUNT.
- State ALIGN (runs at each boundary):
  - nsr==COMMA: comma_cnt++; when comma_cnt+1==SYNC_COUNT go to ACTIVE.
  - Otherwise: HUNT, comma_cnt<=0.
  - No valid_out in ALIGN.
- State ACTIVE (runs at each boundary):
  - nsr!=COMMA: data_out<=nsr, valid_out<=1 for exactly one cycle.
  - nsr==COMMA: valid_out stays 0 and data_out holds its previous value.
  - ACTIVE persists; there is no automatic loss of lock.
- lock_out: registered, equal to (state==ACTIVE). It rises on the same edge that samples the last bit of the SYNC_COUNT-th comma.
- valid_out: 0 on every non-boundary cycle. At most one pulse per WIDTH cycles.
- resync: resync=1 at an edge forces HUNT, comma_cnt=0, lock_out=0, valid_out=0. It overrides any same-edge boundary event; data_out holds. A comma completing on that same edge is ignored, so hunting starts on the next bit.
- Latency: data_out/valid_out update on the edge sampling the word's last bit (0 cycles beyond the serial word).
- comma_cnt width: $clog2(SYNC_COUNT+1).

Test Plan:
1. Reset: hold reset_L=0 for 5 clk while data_in toggles -> data_out=0, valid_out=0, lock_out=0. Release -> all outputs remain 0 with data_in=0.
2. Lock and data (WIDTH=8, MSB_FIRST=1): send 3 bits of 0, then 4×8'hBC (10111100), then 8'h5A -> lock_out rises on the edge of the 32nd BC bit. Exactly one valid_out pulse with data_out=8'h5A occurs 8 edges later, and no valid pulse during the commas.
3. Broken alignment: 2×BC, 8'h00, 4×BC, 8'h3C -> after 8'h00 the block returns to HUNT with lock_out=0. It relocks on the 4th BC of the second run, and valid_out pulses once with data_out=8'h3C.
4. Comma while locked: locked with data_out=8'h5A, send BC, BC, 8'hA5 -> no pulses for the commas and data_out stays 8'h5A. One pulse follows with 8'hA5.
5. Resync and reset mid-word: assert resync at bit 3 of a data word -> lock_out=0 next edge and no pulse for that word. Assert reset_L=0 mid-word while locked -> outputs clear asynchronously, before the next clk edge.
6. Parameters WIDTH=10, COMMA=10'h0FA, SYNC_COUNT=2, MSB_FIRST=0: send the comma LSB-first twice, then 10'h155 LSB-first -> lock_out rises on the 20th comma bit. valid_out pulses with data_out=10'h155.
